keccak_round_seq: RTL and testbench
===================================

Name: keccak_round_seq

Overview:
- Round sequencer for the low-throughput Keccak-f[1600] core.
- Sits directly upstream of the round-constant lookup. It drives the one-hot round index that the lookup decodes into the 64-bit iota constant.
- Accepts a "block ready" handshake from the padder/absorb stage and steps the permutation datapath through NR rounds, one per cycle.
- Presents a held done handshake to the squeeze/output stage.

Parameters:
- NR, 24, number of permutation rounds; also the width of the one-hot round index (must be >= 2).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  absorbed state is ready for permutation.
- in_ready  out  1  sequencer can accept a new permutation this cycle.
- load  out  1  one-cycle pulse: datapath latches the absorbed state (the accept cycle).
- round  out  NR  one-hot round index to the round-constant lookup; bit k = round k. All-zero when not running.
- round_en  out  1  datapath applies one round this cycle.
- last_round  out  1  high while round[NR-1] is set.
- out_valid  out  1  permutation complete; state register holds the result.
- out_ready  in  1  consumer takes the result.
- abort  in  1  present only with SEQ_ABORT_EN.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, round=0, round_en=0, last_round=0, load=0, out_valid=0. in_ready becomes 1 once reset is deasserted.
- States: IDLE, RUN, DONE; 2-bit encoded register.
- Combinational handshake outputs:
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - load = in_valid & in_ready.
  - round_en = (state==RUN).
  - last_round = round[NR-1].
  - out_valid = (state==DONE).
- IDLE: on load, next state=RUN and round <= one-hot bit 0. Otherwise hold; round stays 0.
- RUN: each cycle, round shifts left by one (round <= {round[NR-2:0],1'b0}).
  - When last_round=1, next state=DONE and round <= 0.
  - RUN lasts exactly NR cycles. in_valid is ignored and in_ready=0.
- DONE: out_valid stays high until out_ready=1.
  - out_ready=1 and in_valid=0: next state=IDLE.
  - out_ready=1 and in_valid=1 (same cycle): back-to-back. load pulses, next state=RUN, round <= bit 0. No idle bubble.
- Latency: load in cycle 0. round bit k is high in cycle k+1 (k=0..NR-1). out_valid is high from cycle NR+1.
- Invariant: round is one-hot in RUN and all-zero otherwise. Never more than one bit set.
- Throughput: one permutation per NR+1 cycles with back-to-back handshakes.
- Reset asserted mid-RUN: immediate return to reset values. No done pulse is produced; the partial permutation is discarded.
- out_ready while not in DONE: ignored.

Optional Feature:
- Macro: SEQ_ABORT_EN.
- Defined: adds input port abort.
  - abort=1 in RUN or DONE forces next state=IDLE and round <= 0 on the next edge.
  - No out_valid is produced for an aborted run.
  - abort has priority over load, shift and the DONE handshake.
  - abort in IDLE: load is suppressed that cycle (in_ready is forced to 0).
- Undefined: no abort port; behaviour exactly as above.

Test Plan:
- Reset then in_valid=1 for one cycle, out_ready=1 -> load pulse in cycle 0; round=0x000001 in cycle 1, 0x800000 in cycle 24 with last_round=1; out_valid=1 in cycle 25; IDLE in cycle 26.
- Hold out_ready=0 for 10 cycles after completion -> out_valid stays 1, round stays 0, in_ready=0; release -> IDLE next cycle.
- In DONE, in_valid=1 and out_ready=1 together -> load pulse that cycle, round=0x000001 next cycle; second out_valid exactly 25 cycles after the first.
- Assert reset=0 asynchronously in RUN at round bit 10 -> all outputs return to reset values immediately, before the next edge; with in_valid=1 held, in_ready returns to 1 after release.
- Every cycle of a 1000-cycle random in_valid/out_ready run -> round is one-hot or zero; round_en == |round; NR round_en cycles per completed permutation.
- With SEQ_ABORT_EN: abort=1 at round bit 5 -> IDLE and round=0 next cycle; out_valid never asserts for that run; a new in_valid is then accepted normally.

Source files
------------

// File: rtl/keccak_round_seq.sv
// keccak_round_seq: round sequencer for the low-throughput Keccak-f[1600] core.
// Accepts an absorbed block, steps the datapath through NR rounds (one per
// cycle) while driving a one-hot round index to the round-constant lookup,
// then holds a done handshake until the squeeze stage takes the result.
// Optional feature macro: SEQ_ABORT_EN (adds the abort input).
module keccak_round_seq #(
    parameter int unsigned NR = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          load,
    output logic [NR-1:0] round,
    output logic          round_en,
    output logic          last_round,
    output logic          out_valid,
    input  logic          out_ready
`ifdef SEQ_ABORT_EN
    ,
    input  logic          abort
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [NR-1:0] ROUND_FIRST = NR'(1);

    state_e        state_q, state_d;
    logic [NR-1:0] round_q, round_d;
    logic          abort_w;

`ifdef SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Handshake outputs; in_ready is held low while reset is asserted so no
    // block can be accepted until the sequencer is out of reset.
    always_comb begin
        in_ready   = reset & ~abort_w &
                     ((state_q == IDLE) | ((state_q == DONE) & out_ready));
        load       = in_valid & in_ready;
        round_en   = (state_q == RUN);
        last_round = round_q[NR-1];
        out_valid  = (state_q == DONE);
        round      = round_q;
    end

    // Next-state and round-index update; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        unique case (state_q)
            IDLE: begin
                round_d = '0;
                if (load) begin
                    state_d = RUN;
                    round_d = ROUND_FIRST;
                end
            end
            RUN: begin
                if (round_q[NR-1]) begin
                    state_d = DONE;
                    round_d = '0;
                end else begin
                    round_d = {round_q[NR-2:0], 1'b0};
                end
            end
            DONE: begin
                round_d = '0;
                if (out_ready) begin
                    if (load) begin
                        state_d = RUN;
                        round_d = ROUND_FIRST;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
            end
        endcase
        if (abort_w && (state_q != IDLE)) begin
            state_d = IDLE;
            round_d = '0;
        end
    end

    // State and round-index registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

endmodule

// File: tb/tb_keccak_round_seq.sv
// tb_keccak_round_seq: directed self-checking bench for keccak_round_seq.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_keccak_round_seq;

    localparam int unsigned NR = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          load;
    logic [NR-1:0] round;
    logic          round_en;
    logic          last_round;
    logic          out_valid;
    logic          out_ready;
`ifdef SEQ_ABORT_EN
    logic          abort;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    keccak_round_seq #(.NR(NR)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .load       (load),
        .round      (round),
        .round_en   (round_en),
        .last_round (last_round),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef SEQ_ABORT_EN
        ,
        .abort      (abort)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned cnt;
        int unsigned perm_rounds;
        int unsigned completions;
        logic        seen;

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef SEQ_ABORT_EN
        abort     = 1'b0;
`endif

        // Reset values
        #2;
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_load",      64'(load),      64'd0);
        check("rst_round",     64'(round),     64'd0);
        check("rst_round_en",  64'(round_en),  64'd0);
        check("rst_last",      64'(last_round),64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1 check("rst_rel_in_ready", 64'(in_ready), 64'd1);
        next_cycle();

        // Test 1: single permutation with immediate consumer
        in_valid = 1'b1; out_ready = 1'b1; #1;
        check("t1_load",     64'(load),     64'd1);
        check("t1_in_ready", 64'(in_ready), 64'd1);
        check("t1_round0",   64'(round),    64'd0);
        next_cycle(); in_valid = 1'b0; #1;
        check("t1_first_round", 64'(round), 64'h000001);
        for (int k = 0; k < int'(NR); k++) begin
            check("t1_round",     64'(round),      64'd1 << k);
            check("t1_round_en",  64'(round_en),   64'd1);
            check("t1_last",      64'(last_round), (k == int'(NR) - 1) ? 64'd1 : 64'd0);
            check("t1_in_ready",  64'(in_ready),   64'd0);
            check("t1_out_valid", 64'(out_valid),  64'd0);
            if (k == int'(NR) - 1) check("t1_final_round", 64'(round), 64'h800000);
            next_cycle(); #1;
        end
        check("t1_done_valid", 64'(out_valid), 64'd1);
        check("t1_done_round", 64'(round),     64'd0);
        check("t1_done_ren",   64'(round_en),  64'd0);
        next_cycle(); #1;
        check("t1_idle_valid", 64'(out_valid), 64'd0);
        check("t1_idle_ready", 64'(in_ready),  64'd1);

        // Test 2: consumer stalls for 10 cycles
        next_cycle();
        in_valid = 1'b1; out_ready = 1'b0; #1;
        check("t2_load", 64'(load), 64'd1);
        next_cycle(); in_valid = 1'b0;
        repeat (NR) next_cycle();
        #1;
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_valid", 64'(out_valid), 64'd1);
            check("t2_hold_round", 64'(round),     64'd0);
            check("t2_hold_ready", 64'(in_ready),  64'd0);
            next_cycle(); #1;
        end
        out_ready = 1'b1; #1;
        check("t2_rel_ready", 64'(in_ready),  64'd1);
        check("t2_rel_valid", 64'(out_valid), 64'd1);
        next_cycle(); out_ready = 1'b0; #1;
        check("t2_idle_valid", 64'(out_valid), 64'd0);
        check("t2_idle_ready", 64'(in_ready),  64'd1);

        // Test 3: back-to-back load from DONE
        next_cycle();
        in_valid = 1'b1; out_ready = 1'b0; #1;
        check("t3_load1", 64'(load), 64'd1);
        next_cycle(); in_valid = 1'b0;
        repeat (NR) next_cycle();
        #1;
        check("t3_done1", 64'(out_valid), 64'd1);
        in_valid = 1'b1; out_ready = 1'b1; #1;
        check("t3_b2b_load",  64'(load),     64'd1);
        check("t3_b2b_ready", 64'(in_ready), 64'd1);
        next_cycle(); in_valid = 1'b0; #1;
        check("t3_b2b_round", 64'(round),    64'h000001);
        check("t3_b2b_ren",   64'(round_en), 64'd1);
        cnt = 1;
        while (!out_valid && cnt < 40) begin
            next_cycle(); #1;
            cnt++;
        end
        check("t3_b2b_gap", 64'(cnt), 64'(NR + 1));
        next_cycle(); #1;
        check("t3_idle_valid", 64'(out_valid), 64'd0);

        // Test 4: asynchronous reset in the middle of a run
        next_cycle();
        in_valid = 1'b1; out_ready = 1'b1; #1;
        check("t4_load", 64'(load), 64'd1);
        repeat (11) next_cycle();
        #1;
        check("t4_round10", 64'(round), 64'd1 << 10);
        #1 reset = 1'b0;
        #1;
        check("t4_rst_round",  64'(round),      64'd0);
        check("t4_rst_ren",    64'(round_en),   64'd0);
        check("t4_rst_last",   64'(last_round), 64'd0);
        check("t4_rst_valid",  64'(out_valid),  64'd0);
        check("t4_rst_load",   64'(load),       64'd0);
        check("t4_rst_ready",  64'(in_ready),   64'd0);
        #2 reset = 1'b1;
        #1;
        check("t4_rel_ready", 64'(in_ready), 64'd1);
        check("t4_rel_load",  64'(load),     64'd1);
        next_cycle(); in_valid = 1'b0; #1;
        check("t4_new_round", 64'(round), 64'h000001);
        repeat (NR) next_cycle();
        #1;
        check("t4_new_done", 64'(out_valid), 64'd1);
        next_cycle(); #1;
        check("t4_new_idle", 64'(out_valid), 64'd0);

        // Random handshakes: structural invariants and rounds per permutation
        perm_rounds = 0;
        completions = 0;
        for (int c = 0; c < 1000; c++) begin
            next_cycle();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            check("rnd_onehot0",  64'($onehot0(round)), 64'd1);
            check("rnd_round_en", 64'(round_en),        64'(|round));
            if (out_valid && out_ready) begin
                check("rnd_rounds", 64'(perm_rounds), 64'(NR));
                completions++;
            end
            if (load) perm_rounds = 0;
            if (round_en) perm_rounds++;
        end
        check("rnd_completed", 64'(completions > 0), 64'd1);

        // Drain back to IDLE
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (NR + 3) next_cycle();
        #1;
        check("drain_idle", 64'(in_ready), 64'd1);

`ifdef SEQ_ABORT_EN
        // Abort mid-run, then abort while idle
        next_cycle();
        in_valid = 1'b1; #1;
        check("ab_load", 64'(load), 64'd1);
        repeat (6) next_cycle();
        in_valid = 1'b0; abort = 1'b1; #1;
        check("ab_round5", 64'(round),    64'd1 << 5);
        check("ab_ready",  64'(in_ready), 64'd0);
        next_cycle(); abort = 1'b0; #1;
        check("ab_idle_round", 64'(round),    64'd0);
        check("ab_idle_ren",   64'(round_en), 64'd0);
        check("ab_idle_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (30) begin
            next_cycle(); #1;
            if (out_valid) seen = 1'b1;
        end
        check("ab_no_valid", 64'(seen), 64'd0);
        next_cycle();
        in_valid = 1'b1; abort = 1'b1; #1;
        check("ab_idle_sup_ready", 64'(in_ready), 64'd0);
        check("ab_idle_sup_load",  64'(load),     64'd0);
        abort = 1'b0; #1;
        check("ab_reload", 64'(load), 64'd1);
        next_cycle(); in_valid = 1'b0; #1;
        check("ab_reload_round", 64'(round), 64'h000001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
